// File: rtl/rsnn_cfg_pkg.sv
// ============================================================================
// rsnn_cfg_pkg : shared configuration constants and helpers for the RSNN core
// Rev 1.0
// ============================================================================
`default_nettype none

package rsnn_cfg_pkg;

  // Fill-state encoding, derived from the chunk counter
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FILLING = 2'd1,
    ST_FULL    = 2'd2
  } fill_state_e;

  function automatic int chunks_f(input int l, input int in_w);
    return (l + in_w - 1) / in_w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/bank_slot.sv
// ============================================================================
// bank_slot : one WIDTH-bit active configuration register with load enable
// Rev 1.0
// ============================================================================
`default_nettype none

module bank_slot #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] val_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      val_q <= '0;
    end else if (en_i) begin
      val_q <= d_i;
    end
  end

  assign q_o = val_q;

endmodule

`default_nettype wire

// File: rtl/shadow_register_bank.sv
// ============================================================================
// shadow_register_bank : double-buffered configuration bank, chunked shadow
// fill with atomic commit, fill tracking and sticky protocol error.
// Rev 1.0
// ============================================================================
`default_nettype none

module shadow_register_bank
  import rsnn_cfg_pkg::*;
#(
  parameter  int WIDTH    = 3,
  parameter  int NUM_REGS = 8,
  parameter  int IN_W     = 4,
  localparam int CW       = $clog2(chunks_f(NUM_REGS * WIDTH, IN_W) + 1)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      clear,
  input  logic                      load_en,
  input  logic [IN_W-1:0]           load_data,
  input  logic                      commit,
  output logic [NUM_REGS*WIDTH-1:0] data_out,
  output logic [CW-1:0]             fill_count,
  output logic                      busy,
  output logic                      full,
  output logic                      updated,
  output logic                      err
);

  localparam int          L        = NUM_REGS * WIDTH;
  localparam int          CHUNKS   = chunks_f(L, IN_W);
  localparam int          SW       = CHUNKS * IN_W;
  localparam logic [CW-1:0] CHUNKS_C = CW'(CHUNKS);

  logic [SW-1:0] shadow_q, shadow_d;
  logic [CW-1:0] count_q, count_d;
  logic          err_q, err_d;
  logic          busy_q, full_q, updated_q;
  logic          commit_ok;
  fill_state_e   state;

  always_comb begin
    if (count_q == '0)           state = ST_IDLE;
    else if (count_q == CHUNKS_C) state = ST_FULL;
    else                         state = ST_FILLING;
  end

  always_comb begin
    shadow_d  = shadow_q;
    count_d   = count_q;
    err_d     = err_q;
    commit_ok = 1'b0;
    if (clear) begin
      shadow_d = '0;
      count_d  = '0;
      err_d    = 1'b0;
    end else if (commit && state == ST_FULL) begin
      commit_ok = 1'b1;
      count_d   = '0;
    end else begin
      if (commit) begin
        err_d = 1'b1;
      end
      if (load_en) begin
        if (state == ST_FULL) begin
          err_d = 1'b1;
        end else begin
          // Shifting the concatenation keeps this valid even for a one-chunk chain
          shadow_d = SW'({load_data, shadow_q} >> IN_W);
          count_d  = count_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow_q  <= '0;
      count_q   <= '0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
      full_q    <= 1'b0;
      updated_q <= 1'b0;
    end else begin
      shadow_q  <= shadow_d;
      count_q   <= count_d;
      err_q     <= err_d;
      busy_q    <= (count_d != '0) && (count_d != CHUNKS_C);
      full_q    <= (count_d == CHUNKS_C);
      updated_q <= commit_ok;
    end
  end

  for (genvar r = 0; r < NUM_REGS; r++) begin : g_slot
    bank_slot #(
      .WIDTH (WIDTH)
    ) u_slot (
      .clk   (clk),
      .reset (reset),
      .en_i  (commit_ok),
      .d_i   (shadow_q[r*WIDTH +: WIDTH]),
      .q_o   (data_out[r*WIDTH +: WIDTH])
    );
  end

  assign fill_count = count_q;
  assign busy       = busy_q;
  assign full       = full_q;
  assign updated    = updated_q;
  assign err        = err_q;

endmodule

`default_nettype wire

// File: tb/tb_shadow_register_bank.sv
// ============================================================================
// tb_shadow_register_bank : directed self-checking bench with commit scoreboard
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_shadow_register_bank;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        clear = 1'b0;
  logic        load_en = 1'b0;
  logic [3:0]  load_data = '0;
  logic        commit = 1'b0;
  logic [23:0] data_out;
  logic [2:0]  fill_count;
  logic        busy, full, updated, err;

  int passed = 0;
  int total  = 0;
  logic [23:0] exp_q[$];

  shadow_register_bank #(
    .WIDTH    (3),
    .NUM_REGS (8),
    .IN_W     (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .clear      (clear),
    .load_en    (load_en),
    .load_data  (load_data),
    .commit     (commit),
    .data_out   (data_out),
    .fill_count (fill_count),
    .busy       (busy),
    .full       (full),
    .updated    (updated),
    .err        (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Compare data_out against the oldest pending commit whenever updated pulses
  task automatic sb_check();
    if (updated === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("sb_unexpected_updated", 32'(updated), 32'd0);
      end else begin
        chk("sb_data_out", 32'(data_out), 32'(exp_q.pop_front()));
      end
    end
  endtask

  task automatic cyc(input logic ld, input logic [3:0] d, input logic cm, input logic cl);
    @(negedge clk);
    load_en = ld; load_data = d; commit = cm; clear = cl;
    @(posedge clk);
    #1;
    load_en = 1'b0; load_data = '0; commit = 1'b0; clear = 1'b0;
    sb_check();
  endtask

  task automatic load(input logic [3:0] d);
    cyc(1'b1, d, 1'b0, 1'b0);
  endtask

  task automatic do_commit(input logic [23:0] expect_val, input logic push);
    if (push) exp_q.push_back(expect_val);
    cyc(1'b0, 4'h0, 1'b1, 1'b0);
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst_data_out", 32'(data_out), 32'd0);
    chk("rst_fill_count", 32'(fill_count), 32'd0);
    chk("rst_flags", {28'd0, busy, full, updated, err}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Full load and commit
    load(4'h1); load(4'h2); load(4'h3);
    chk("fill3_busy_full", {30'd0, busy, full}, 32'b10);
    load(4'h4); load(4'h5); load(4'h6);
    chk("fill6_count", 32'(fill_count), 32'd6);
    chk("fill6_busy_full", {30'd0, busy, full}, 32'b01);
    do_commit(24'h654321, 1'b1);
    chk("commit1_updated", 32'(updated), 32'd1);
    chk("commit1_reg0", 32'(data_out[2:0]), 32'd1);
    chk("commit1_reg1", 32'(data_out[5:3]), 32'd4);
    chk("commit1_count", 32'(fill_count), 32'd0);
    chk("commit1_err", 32'(err), 32'd0);
    cyc(1'b0, 4'h0, 1'b0, 1'b0);
    chk("updated_one_cycle", 32'(updated), 32'd0);

    // Early commit
    load(4'h7); load(4'h8); load(4'h9);
    do_commit(24'h0, 1'b0);
    chk("early_data_out", 32'(data_out), 32'h654321);
    chk("early_err", 32'(err), 32'd1);
    chk("early_count", 32'(fill_count), 32'd3);
    chk("early_updated", 32'(updated), 32'd0);
    load(4'hA); load(4'hB); load(4'hC);
    do_commit(24'hCBA987, 1'b1);
    chk("early_err_sticky", 32'(err), 32'd1);

    // Overflow while FULL
    cyc(1'b0, 4'h0, 1'b0, 1'b1);
    chk("clear_err", 32'(err), 32'd0);
    for (int i = 1; i <= 6; i++) load(4'(i));
    load(4'hF);
    chk("ovf_err", 32'(err), 32'd1);
    chk("ovf_count", 32'(fill_count), 32'd6);
    do_commit(24'h654321, 1'b1);

    // commit + load together in FULL
    cyc(1'b0, 4'h0, 1'b0, 1'b1);
    for (int i = 6; i >= 1; i--) load(4'(i));
    exp_q.push_back(24'h123456);
    cyc(1'b1, 4'hE, 1'b1, 1'b0);
    chk("sim_full_count", 32'(fill_count), 32'd0);
    chk("sim_full_err", 32'(err), 32'd0);
    chk("sim_full_data", 32'(data_out), 32'h123456);

    // commit + load together at count 2
    load(4'h1); load(4'h2);
    cyc(1'b1, 4'h3, 1'b1, 1'b0);
    chk("sim_cnt2_count", 32'(fill_count), 32'd3);
    chk("sim_cnt2_err", 32'(err), 32'd1);
    chk("sim_cnt2_data", 32'(data_out), 32'h123456);

    // Clear mid-fill at count 4
    load(4'h4);
    chk("pre_clear_count", 32'(fill_count), 32'd4);
    cyc(1'b1, 4'h5, 1'b1, 1'b1);
    chk("clear_count", 32'(fill_count), 32'd0);
    chk("clear_err2", 32'(err), 32'd0);
    chk("clear_data_kept", 32'(data_out), 32'h123456);
    chk("clear_busy", 32'(busy), 32'd0);
    load(4'hA);
    for (int i = 0; i < 5; i++) load(4'h0);
    do_commit(24'h00000A, 1'b1);
    chk("fresh_data", 32'(data_out), 32'h00000A);

    // Asynchronous reset during FILLING
    load(4'h3); load(4'h4);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("arst_data_out", 32'(data_out), 32'd0);
    chk("arst_count", 32'(fill_count), 32'd0);
    chk("arst_flags", {28'd0, busy, full, updated, err}, 32'd0);
    reset = 1'b0;
    load_en = 1'b1; load_data = 4'h5;
    @(posedge clk);
    #1;
    load_en = 1'b0;
    chk("arst_next_count", 32'(fill_count), 32'd1);
    chk("arst_next_busy", 32'(busy), 32'd1);

    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
